// File: rtl/my_pkg.sv
// Shared types for the memory-port arbiter: store size codes, queue entry
// layout and the byte-lane/shift helper used when a store hits the port.
package my_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_entry_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] wdata;
  } lane_t;

  // Size 2'b11 falls through to the word case.
  function automatic lane_t lane_gen(input logic [1:0] size,
                                     input logic [1:0] a,
                                     input logic [31:0] d);
    lane_t r;
    case (size)
      SIZE_HALF: begin
        r.we    = a[1] ? 4'b1100 : 4'b0011;
        r.wdata = d << {a[1], 4'b0000};
      end
      SIZE_BYTE: begin
        r.we    = 4'b0001 << a;
        r.wdata = d << {a, 3'b000};
      end
      default: begin
        r.we    = 4'b1111;
        r.wdata = d;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// In-order circular store queue. Exposes every slot's word address with a
// live mask so the arbiter can detect load/store overlap in parallel.
module store_fifo
  import my_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  st_entry_t              i_din,
  input  logic                   i_pop,
  output st_entry_t              o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [AW:0]            o_count,
  output logic [DEPTH-1:0][29:0] o_waddr,
  output logic [DEPTH-1:0]       o_vld
);

  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  st_entry_t     r_mem [DEPTH];
  logic          w_push, w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Payload needs no reset: the live mask gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_view
    logic [AW-1:0] w_off;
    assign w_off      = AW'(k) - r_rd;
    assign o_waddr[k] = r_mem[k].addr[31:2];
    assign o_vld[k]   = ({1'b0, w_off} < r_count);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single data-memory port shared by retire-stage stores (queued) and
// memory-unit loads (priority unless blocked, queue full or word overlap).
module mem_arbiter
  import my_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ready,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  output logic        ld_ack,
  output logic        mem_ce,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        st_empty
);

  st_entry_t              w_din, w_head;
  logic                   w_full, w_empty, w_push, w_pop, w_ld_go, w_hit;
  logic [AW:0]            w_count;
  logic [DEPTH-1:0][29:0] w_waddr;
  logic [DEPTH-1:0]       w_vld;
  lane_t                  w_lane;
  logic                   w_unused;

  logic        r_ce, r_ack;
  logic [3:0]  r_we;
  logic [31:0] r_addr, r_wdata;

  assign w_din    = '{addr: st_addr, data: st_data, size: st_size};
  assign st_ready = !w_full;
  assign st_empty = w_empty;
  assign w_push   = st_valid && st_ready;
  assign w_unused = ^ld_addr[1:0];

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_waddr (w_waddr),
    .o_vld   (w_vld)
  );

  // The store being pushed this edge counts as pending for the overlap check.
  always_comb begin
    w_hit = w_push && (st_addr[31:2] == ld_addr[31:2]);
    for (int k = 0; k < DEPTH; k++)
      if (w_vld[k] && (w_waddr[k] == ld_addr[31:2])) w_hit = 1'b1;
  end

  assign w_ld_go = ld_req && !r_ack && !w_hit && (w_count < (AW+1)'(DEPTH));
  assign w_pop   = !w_ld_go && !w_empty;
  assign w_lane  = lane_gen(w_head.size, w_head.addr[1:0], w_head.data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ce    <= 1'b0;
      r_ack   <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_ld_go) begin
      r_ce   <= 1'b1;
      r_ack  <= 1'b1;
      r_we   <= '0;
      r_addr <= {ld_addr[31:2], 2'b00};
    end else if (w_pop) begin
      r_ce    <= 1'b1;
      r_ack   <= 1'b0;
      r_we    <= w_lane.we;
      r_addr  <= {w_head.addr[31:2], 2'b00};
      r_wdata <= w_lane.wdata;
    end else begin
      r_ce  <= 1'b0;
      r_ack <= 1'b0;
      r_we  <= '0;
    end
  end

  assign mem_ce    = r_ce;
  assign ld_ack    = r_ack;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
